pc_return_stack: RTL and testbench
==================================

Name: pc_return_stack

Overview:
- Program-counter stage directly downstream of the instruction-decode controller in the single-cycle 19-bit processor.
- Consumes the controller's pc_src, stack_push and stack_pop outputs plus the current instruction word, and registers the next PC.
- Owns the hardware return-address stack used by jsb and ret.
- Exposes the PC to instruction memory, and exposes stack status and sticky error flags for the testbench and for debug.

Parameters:
- PC_W, 12, program counter width in bits (instruction address space is 2^PC_W words).
- DEPTH, 8, number of return-address stack entries (power of two, at least 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  when 1, all state holds (PC, stack, flags).
- pc_src  input  2  next-PC select: 00 = pc+1; 01 = jump; 10 = return; 11 = taken branch.
- stack_push  input  1  push the return address (jsb).
- stack_pop  input  1  pop the top of stack (ret).
- instruction  input  19  current instruction word.
- pc  output  PC_W  registered current PC.
- pc_plus1  output  PC_W  combinational pc+1, modulo 2^PC_W.
- depth  output  clog2(DEPTH)+1  number of valid stack entries.
- empty  output  1  depth==0.
- full  output  1  depth==DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a return or pop was attempted while empty.
- conflict  output  1  sticky: stack_push and stack_pop were asserted together.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc<=RESET_PC, depth<=0, overflow, underflow and conflict <= 0.
  - Stack RAM contents are not cleared; they are don't-care while their entries are invalid.
  - Reset has priority over stall and over every other input.
- Single-cycle operation: the PC update and any stack update take effect on the same clock edge. There is no pipeline.
- Next-PC targets, all computed modulo 2^PC_W:
  - Jump target = instruction[PC_W-1:0].
  - Branch target = pc_plus1 + sign_extend(instruction[7:0]).
  - Return target = the top-of-stack entry, read before this cycle's pop.
  - pc_src=00 selects pc_plus1.
- Wrap-around: pc = 2^PC_W - 1 with pc_src=00 gives next pc = 0. A branch below 0 or above the maximum wraps the same way.
- Push (stack_push=1, stack_pop=0):
  - If not full: mem[depth] <= pc_plus1 and depth increments.
  - If full: the stack is unchanged and overflow <= 1.
  - In both cases the PC still follows pc_src.
- Pop (stack_pop=1, stack_push=0):
  - If not empty: depth decrements.
  - If empty: depth stays 0 and underflow <= 1.
- Return when empty (pc_src=10 with empty=1): pc <= pc_plus1 and underflow <= 1. A return never loads a stale RAM entry.
- Push and pop together:
  - No stack change, conflict <= 1, pc <= pc_plus1.
  - This overrides pc_src for that cycle only.
- Stack flags without a matching pc_src: stack_push or stack_pop with any pc_src is legal, and the stack acts exactly as defined above.
- stall=1 and rst=0: every register holds. Flags are not set, even if push, pop or a return is requested.
- Sticky flags clear only on reset.
- Inputs are sampled only at the rising edge. Combinational glitches on pc_src and instruction between edges have no effect.
- depth, empty and full are derived from the registered depth count only.

Test Plan:
- Reset, then 3 cycles of pc_src=00 -> pc = 0, 1, 2, 3. Next, with pc = 4095 and pc_src=00 -> pc = 0.
- At pc=10, pc_src=11 with instruction[7:0]=0xFB (-5) -> pc=6. At pc=10, pc_src=01 with instruction[11:0]=0x200 -> pc=0x200.
- At pc=5, jsb (pc_src=01, push=1, target 0x040) -> pc=0x040, depth=1. Then ret (pc_src=10, pop=1) -> pc=6, depth=0, empty=1.
- 8 nested jsb calls from pc=0x100, 0x200, … -> full=1. A 9th jsb -> overflow=1, depth stays 8, PC still jumps. Then 8 rets -> return addresses come back in LIFO order, ending at 0x101.
- ret from reset (empty) at pc=3 -> pc=4, underflow=1, depth=0. A later valid push/pop leaves underflow at 1. Asserting rst clears it.
- push and pop asserted together at pc=7 -> pc=8, conflict=1, depth unchanged. stall=1 with pc_src=01 -> pc, depth and flags all unchanged. rst during a held stall -> pc=0, depth=0.

Source files
------------

// File: rtl/pc_return_stack.sv
// Program-counter register with a hardware return-address stack for jsb/ret.
// Next PC, stack update and sticky error flags all commit on the same rising edge.
module pc_return_stack #(
   parameter int PC_W     = 12,
   parameter int DEPTH    = 8,
   parameter int RESET_PC = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic [1:0]               pc_src,
   input  logic                     stack_push,
   input  logic                     stack_pop,
   input  logic [18:0]              instruction,
   output logic [PC_W-1:0]          pc,
   output logic [PC_W-1:0]          pc_plus1,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     conflict
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   logic [PC_W-1:0] mem [DEPTH];

   logic [PC_W-1:0] pc_reg, pc_next;
   logic [DW-1:0]   depth_reg, depth_next;
   logic            overflow_reg, overflow_next;
   logic            underflow_reg, underflow_next;
   logic            conflict_reg, conflict_next;

   logic            push_only, pop_only, both;
   logic            mem_we;
   logic [AW-1:0]   tos_idx;
   logic [PC_W-1:0] tos_val, jump_tgt, branch_tgt, branch_off;
   logic            unused_instr;

   assign unused_instr = ^instruction[18:PC_W];

   assign push_only = stack_push & ~stack_pop;
   assign pop_only  = stack_pop & ~stack_push;
   assign both      = stack_push & stack_pop;

   assign pc_plus1   = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
   assign jump_tgt   = instruction[PC_W-1:0];
   assign branch_off = {{(PC_W-8){instruction[7]}}, instruction[7:0]};
   assign branch_tgt = pc_plus1 + branch_off;

   // Top of stack is read combinationally so a return and its pop land in one cycle.
   assign tos_idx = depth_reg[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
   assign tos_val = mem[tos_idx];

   assign empty     = (depth_reg == '0);
   assign full      = (depth_reg == DW'(DEPTH));
   assign depth     = depth_reg;
   assign pc        = pc_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
   assign conflict  = conflict_reg;

   assign mem_we = ~rst & ~stall & push_only & ~full;

   always_comb begin
      pc_next        = pc_plus1;
      depth_next     = depth_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      conflict_next  = conflict_reg;

      if (both) begin
         conflict_next = 1'b1;
      end else begin
         unique case (pc_src)
            2'b00: pc_next = pc_plus1;
            2'b01: pc_next = jump_tgt;
            2'b10: begin
               // An empty stack never supplies a stale RAM entry.
               if (empty) underflow_next = 1'b1;
               else       pc_next = tos_val;
            end
            default: pc_next = branch_tgt;
         endcase

         if (push_only) begin
            if (full) overflow_next = 1'b1;
            else      depth_next = depth_reg + {{(DW-1){1'b0}}, 1'b1};
         end

         if (pop_only) begin
            if (empty) underflow_next = 1'b1;
            else       depth_next = depth_reg - {{(DW-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg        <= PC_W'(RESET_PC);
         depth_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         conflict_reg  <= 1'b0;
      end else if (!stall) begin
         pc_reg        <= pc_next;
         depth_reg     <= depth_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
         conflict_reg  <= conflict_next;
      end
   end

   // Stack storage is left uninitialised; entries at or above depth are don't-care.
   always_ff @(posedge clk) begin
      if (mem_we) mem[depth_reg[AW-1:0]] <= pc_plus1;
   end

endmodule

// File: tb/tb_pc_return_stack.sv
// Scoreboard bench: stimulus queues hand-computed expected state per edge,
// a monitor pops and compares after every rising edge.
module tb_pc_return_stack;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  pc_src = 2'b00;
   logic        stack_push = 1'b0;
   logic        stack_pop = 1'b0;
   logic [18:0] instruction = '0;
   logic [11:0] pc, pc_plus1;
   logic [3:0]  depth;
   logic        empty, full, overflow, underflow, conflict;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string name;
      int    pc;
      int    depth;
      bit    ovf;
      bit    unf;
      bit    conf;
   } exp_t;

   exp_t exp_q[$];

   // Hand-maintained expected flag/depth state, set explicitly by the sequence.
   int e_depth = 0;
   bit e_ovf = 0, e_unf = 0, e_conf = 0;

   pc_return_stack #(.PC_W(12), .DEPTH(8), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
      .stack_push(stack_push), .stack_pop(stack_pop), .instruction(instruction),
      .pc(pc), .pc_plus1(pc_plus1), .depth(depth), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow), .conflict(conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input string field, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
      end
   endtask

   // Monitor: one transaction per edge while expectations are outstanding.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "pc", int'(pc), e.pc);
            chk(e.name, "pc_plus1", int'(pc_plus1), (e.pc + 1) % 4096);
            chk(e.name, "depth", int'(depth), e.depth);
            chk(e.name, "empty", int'(empty), int'(e.depth == 0));
            chk(e.name, "full", int'(full), int'(e.depth == 8));
            chk(e.name, "overflow", int'(overflow), int'(e.ovf));
            chk(e.name, "underflow", int'(underflow), int'(e.unf));
            chk(e.name, "conflict", int'(conflict), int'(e.conf));
            $display("txn %-10s pc=%03h depth=%0d ovf=%0b unf=%0b conf=%0b",
                     e.name, pc, depth, overflow, underflow, conflict);
         end
      end
   end

   task automatic step(input string name, input bit r, input bit s, input logic [1:0] src,
                       input bit pu, input bit po, input int instr, input int e_pc);
      exp_t e;
      @(negedge clk);
      rst = r; stall = s; pc_src = src; stack_push = pu; stack_pop = po;
      instruction = 19'(instr);
      e.name = name; e.pc = e_pc; e.depth = e_depth;
      e.ovf = e_ovf; e.unf = e_unf; e.conf = e_conf;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input string name);
      e_depth = 0; e_ovf = 0; e_unf = 0; e_conf = 0;
      step(name, 1, 0, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic jmp(input int target);
      step("jump", 0, 0, 2'b01, 0, 0, target, target);
   endtask

   initial begin
      do_reset("reset");
      step("inc1", 0, 0, 2'b00, 0, 0, 0, 1);
      step("inc2", 0, 0, 2'b00, 0, 0, 0, 2);
      step("inc3", 0, 0, 2'b00, 0, 0, 0, 3);

      // Return from an empty stack falls through to pc+1.
      e_unf = 1;
      step("ret_empty", 0, 0, 2'b10, 0, 1, 0, 4);
      e_depth = 1;
      step("push_ok", 0, 0, 2'b00, 1, 0, 0, 5);
      e_depth = 0;
      step("pop_ok", 0, 0, 2'b00, 0, 1, 0, 6);
      do_reset("rst_unf");

      jmp(12'hFFF);
      step("wrap_inc", 0, 0, 2'b00, 0, 0, 0, 0);
      jmp(10);
      step("br_neg", 0, 0, 2'b11, 0, 0, 'h0FB, 6);
      jmp(10);
      step("jmp_200", 0, 0, 2'b01, 0, 0, 'h200, 'h200);
      jmp(1);
      step("br_wrapdn", 0, 0, 2'b11, 0, 0, 'h0FB, 'hFFD);
      jmp(12'hFFE);
      step("br_wrapup", 0, 0, 2'b11, 0, 0, 'h07F, 'h07E);

      jmp(5);
      e_depth = 1;
      step("jsb", 0, 0, 2'b01, 1, 0, 'h040, 'h040);
      e_depth = 0;
      step("ret", 0, 0, 2'b10, 0, 1, 0, 6);

      jmp('h100);
      for (int k = 1; k <= 8; k++) begin
         e_depth = k;
         step("jsb_nest", 0, 0, 2'b01, 1, 0, (k + 1) * 'h100, (k + 1) * 'h100);
      end
      e_ovf = 1;
      step("jsb_ovf", 0, 0, 2'b01, 1, 0, 'hA00, 'hA00);
      for (int k = 8; k >= 1; k--) begin
         e_depth = k - 1;
         step("ret_nest", 0, 0, 2'b10, 0, 1, 0, k * 'h100 + 1);
      end

      do_reset("rst2");
      jmp(6);
      e_depth = 1;
      step("push7", 0, 0, 2'b00, 1, 0, 0, 7);
      e_conf = 1;
      step("conflict", 0, 0, 2'b01, 1, 1, 'h300, 8);
      step("stall_jmp", 0, 1, 2'b01, 1, 0, 'h123, 8);
      step("stall_ret", 0, 1, 2'b10, 0, 1, 0, 8);
      do_reset("rst_stall");
      rst = 1'b1;
      exp_q[exp_q.size() - 1].name = "rst_stall";
      stall = 1'b1;

      // Return without pop reads top of stack but keeps it.
      e_depth = 1;
      step("push0", 0, 0, 2'b00, 1, 0, 0, 1);
      jmp('h050);
      step("ret_nopop", 0, 0, 2'b10, 0, 0, 0, 1);

      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d pending, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
